// File: rtl/sad_best_match_if.sv
// Handshake/result bundle between the SAD datapath, the best-match search
// and the motion-vector writer.
interface sad_best_match_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 6
) ();
  logic                 start;
  logic                 sad_valid;
  logic [WIDTH+4:0]     sad_in;
  logic                 busy;
  logic                 done;
  logic [WIDTH+4:0]     best_sad;
  logic [IDX_W-1:0]     best_idx;

  modport master (
    output start, sad_valid, sad_in,
    input  busy, done, best_sad, best_idx
  );

  modport slave (
    input  start, sad_valid, sad_in,
    output busy, done, best_sad, best_idx
  );
endinterface

// File: rtl/sad_best_match.sv
// Block-matching search: tracks the minimum SAD over NUM_CAND candidates
// (earliest index wins ties) and publishes it with a one-cycle done pulse.
module sad_best_match #(
  parameter int WIDTH    = 8,
  parameter int NUM_CAND = 64,
  parameter int IDX_W    = 6
) (
  input  logic            clk,
  input  logic            rst,
  sad_best_match_if.slave bus
);
  localparam int SW = WIDTH + 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    run_min_q, run_min_d;
  logic [IDX_W-1:0] run_idx_q, run_idx_d;
  logic [SW-1:0]    best_sad_q, best_sad_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Running minimum including the current sample, so the final sample
  // can be folded into best_* on the same edge it is accepted.
  logic             take;
  logic [SW-1:0]    cur_min;
  logic [IDX_W-1:0] cur_idx;

  always_comb begin
    take    = (cnt_q == '0) || (bus.sad_in < run_min_q);
    cur_min = take ? bus.sad_in : run_min_q;
    cur_idx = take ? cnt_q : run_idx_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    run_min_d  = run_min_q;
    run_idx_d  = run_idx_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_SEARCH;
          cnt_d     = '0;
          run_min_d = '1;
          run_idx_d = '0;
        end
      end
      ST_SEARCH: begin
        if (bus.start) begin
          // Restart discards any sample presented in the same cycle.
          cnt_d     = '0;
          run_min_d = '1;
          run_idx_d = '0;
        end else if (bus.sad_valid) begin
          run_min_d = cur_min;
          run_idx_d = cur_idx;
          if (cnt_q == LAST_IDX) begin
            state_d    = ST_DONE;
            cnt_d      = '0;
            best_sad_d = cur_min;
            best_idx_d = cur_idx;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          state_d   = ST_SEARCH;
          cnt_d     = '0;
          run_min_d = '1;
          run_idx_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SEARCH);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      run_min_q  <= '0;
      run_idx_q  <= '0;
      best_sad_q <= '0;
      best_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      run_min_q  <= run_min_d;
      run_idx_q  <= run_idx_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.best_sad = best_sad_q;
  assign bus.best_idx = best_idx_q;
endmodule

// File: tb/tb_sad_best_match.sv
// Bench for sad_best_match with NUM_CAND=4: directed searches plus random
// searches checked against a min-with-earliest-index reference model.
module tb_sad_best_match;
  localparam int WIDTH    = 8;
  localparam int NUM_CAND = 4;
  localparam int IDX_W    = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   held_sad;
  int   held_idx;
  int   sv[NUM_CAND];

  sad_best_match_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  sad_best_match #(.WIDTH(WIDTH), .NUM_CAND(NUM_CAND), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: minimum of the candidate list, earliest index on ties.
  task automatic ref_best(input int v[NUM_CAND], output int s, output int idx);
    s   = v[0];
    idx = 0;
    for (int i = 1; i < NUM_CAND; i++)
      if (v[i] < s) begin
        s   = v[i];
        idx = i;
      end
  endtask

  // Entered in IDLE or DONE (1 ns after an edge); leaves the DUT in DONE.
  task automatic do_search(input int v[NUM_CAND], input int gmin, input int gmax,
                           input int abort_n, input string tag);
    int exp_s;
    int exp_i;
    int ng;
    ref_best(v, exp_s, exp_i);
    bus.start = 1'b1;
    bus.sad_valid = 1'b0;
    tick;
    bus.start = 1'b0;
    if (abort_n > 0) begin
      for (int k = 0; k < abort_n; k++) begin
        bus.sad_valid = 1'b1;
        bus.sad_in = '0;
        tick;
      end
      bus.start = 1'b1;
      bus.sad_valid = 1'b1;
      bus.sad_in = '0;
      tick;
      bus.start = 1'b0;
      bus.sad_valid = 1'b0;
      chk({tag, "_restart_done"}, 32'(bus.done), 0);
    end
    for (int i = 0; i < NUM_CAND; i++) begin
      chk({tag, "_busy"}, 32'(bus.busy), 1);
      chk({tag, "_hold_sad"}, 32'(bus.best_sad), held_sad);
      chk({tag, "_hold_idx"}, 32'(bus.best_idx), held_idx);
      bus.sad_valid = 1'b1;
      bus.sad_in = 13'(v[i]);
      tick;
      bus.sad_valid = 1'b0;
      bus.sad_in = '0;
      if (i < NUM_CAND - 1) begin
        chk({tag, "_early_done"}, 32'(bus.done), 0);
        ng = $urandom_range(gmax, gmin);
        for (int g = 0; g < ng; g++) tick;
      end
    end
    chk({tag, "_done"}, 32'(bus.done), 1);
    chk({tag, "_busy_end"}, 32'(bus.busy), 0);
    chk({tag, "_best_sad"}, 32'(bus.best_sad), exp_s);
    chk({tag, "_best_idx"}, 32'(bus.best_idx), exp_i);
    held_sad = exp_s;
    held_idx = exp_i;
  endtask

  task automatic finish_pulse(input string tag);
    tick;
    chk({tag, "_done_pulse"}, 32'(bus.done), 0);
    chk({tag, "_busy_idle"}, 32'(bus.busy), 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    held_sad = 0;
    held_idx = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.sad_valid = 1'b0;
    bus.sad_in = '0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_sad", 32'(bus.best_sad), 0);
    chk("rst_idx", 32'(bus.best_idx), 0);

    sv = '{300, 120, 450, 200};
    do_search(sv, 0, 0, 0, "basic");
    finish_pulse("basic");

    sv = '{50, 50, 10, 10};
    do_search(sv, 2, 2, 0, "ties");
    finish_pulse("ties");

    sv = '{8191, 8191, 8191, 8191};
    do_search(sv, 0, 1, 0, "allones");
    finish_pulse("allones");
    sv = '{0, 5, 5, 5};
    do_search(sv, 0, 0, 0, "zero");

    sv = '{9, 8, 7, 6};
    do_search(sv, 0, 0, 0, "b2b");
    finish_pulse("b2b");

    sv = '{40, 30, 20, 25};
    do_search(sv, 0, 0, 2, "restart");
    finish_pulse("restart");

    // Reset mid-search: no done, outputs cleared, later samples ignored.
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.sad_valid = 1'b1;
      bus.sad_in = 13'(k + 3);
      tick;
    end
    bus.sad_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_done", 32'(bus.done), 0);
    chk("midrst_sad", 32'(bus.best_sad), 0);
    chk("midrst_idx", 32'(bus.best_idx), 0);
    held_sad = 0;
    held_idx = 0;
    for (int k = 0; k < 4; k++) begin
      bus.sad_valid = 1'b1;
      bus.sad_in = 13'd1;
      tick;
      chk("idle_done", 32'(bus.done), 0);
      chk("idle_busy", 32'(bus.busy), 0);
    end
    bus.sad_valid = 1'b0;
    chk("idle_sad", 32'(bus.best_sad), 0);

    sv = '{70, 60, 90, 80};
    do_search(sv, 0, 0, 0, "idlefilt");
    finish_pulse("idlefilt");

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NUM_CAND; i++)
        sv[i] = ($urandom_range(1, 0) == 1) ? int'($urandom_range(8191, 0))
                                            : int'($urandom_range(3, 0));
      do_search(sv, 0, 2, ($urandom_range(3, 0) == 0) ? 1 : 0, "rand");
      if ($urandom_range(1, 0) == 0) finish_pulse("rand");
    end
    finish_pulse("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sad_best_match.md
Name: sad_best_match

Overview:
- Consumes the SAD value stream from the SAD datapath and runs one block-matching search over NUM_CAND candidate positions.
- Returns the minimum SAD and the index of the candidate that produced it, then pulses `done`.
- Sits directly downstream of the 4x8 SAD stage and upstream of the motion-vector writer.
- Candidate indices are assigned in arrival order of valid samples.

Parameters:
- WIDTH, 8, pixel width. SAD input/output width is WIDTH+5 (max 32*255 = 8160 fits 13 bits).
- NUM_CAND, 64, candidates per search. Legal range is 2..2**IDX_W.
- IDX_W, 6, candidate index width. Must equal clog2(NUM_CAND).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a new search. Sampled in IDLE and DONE; in SEARCH it aborts and restarts.
- sad_valid  in  1  sad_in carries a candidate SAD this cycle.
- sad_in  in  WIDTH+5  SAD value from the upstream stage.
- busy  out  1  high while in SEARCH.
- done  out  1  one-cycle pulse when a search completes.
- best_sad  out  WIDTH+5  minimum SAD of the last completed search.
- best_idx  out  IDX_W  index of the candidate that gave best_sad.

Behaviour:
- Reset (synchronous, active-high; overrides everything, including mid-search):
  - state=IDLE; cnt, run_min, run_idx, best_sad, best_idx=0; busy=0; done=0.
  - An aborted search produces no done and leaves best_* at 0.
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - sad_valid is ignored.
  - start=1 -> SEARCH, with cnt<=0, run_min<=all-ones, run_idx<=0.
- SEARCH, on each cycle with sad_valid=1:
  - Update: if cnt==0 or sad_in < run_min (strict), then run_min<=sad_in and run_idx<=cnt.
  - Then cnt<=cnt+1.
  - Ties keep the earliest index. The cnt==0 forced load makes an all-ones first SAD register correctly.
- SEARCH, cycles with sad_valid=0: all state holds. Gaps of any length are legal.
- Final sample (sad_valid=1 with cnt==NUM_CAND-1):
  - On that edge, best_sad/best_idx load the minimum that includes this sample (compare is applied combinationally).
  - state -> DONE.
  - cnt wraps to 0; cnt never exceeds NUM_CAND-1.
- DONE:
  - done=1 for exactly this one cycle.
  - Next state is SEARCH if start=1 (re-initialise as in IDLE), otherwise IDLE.
  - sad_valid is ignored in DONE.
- start=1 while in SEARCH:
  - Restarts the search: cnt, run_min and run_idx re-initialise.
  - A sad_valid sample in that same cycle is discarded.
  - best_* are untouched.
- Latency: done rises 1 cycle after the edge that accepts the final sample; best_* are valid in that same cycle.
- Output hold: best_sad/best_idx hold until the next completed search. busy=(state==SEARCH), registered.
- Width: compare is unsigned, full WIDTH+5 bits, with no truncation or saturation.

Test Plan:
- Basic search (NUM_CAND=4, WIDTH=8): reset, start, then SADs 300, 120, 450, 200 back-to-back.
  - Expect done pulse one cycle after 4th sample, best_sad=120, best_idx=1.
  - busy is high for 4 cycles.
- Ties and bubbles: SADs 50, 50, 10, 10 with 2-cycle sad_valid gaps between samples.
  - Expect best_sad=10, best_idx=2 (earliest tie).
  - done only after the 4th valid sample.
- Extremes: SADs 8191, 8191, 8191, 8191 -> best_sad=8191, best_idx=0. Next search 0, 5, 5, 5 -> best_sad=0, best_idx=0.
- Back-to-back: start asserted during the DONE cycle.
  - Next search begins immediately with no IDLE cycle.
  - Second result (SADs 9, 8, 7, 6 -> 6, idx 3) is correct.
  - First result is held until then.
- Restart and reset: start mid-search after 2 samples, then 4 new samples 40, 30, 20, 25.
  - Expect best_sad=20, best_idx=2.
  - Separately, assert rst mid-search: no done, and all outputs read 0 the cycle after.
- Idle filtering: sad_valid pulses with SAD=1 while in IDLE, then a start and search 70, 60, 90, 80.
  - Expect best_sad=60, best_idx=1 (idle samples ignored).
